uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/rr_picker.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 114 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   DATA_WIDTH_DEF : default byte width per frame
//   arb_state_t    : arbiter state encoding (IDLE, ISSUE, WAIT_DONE)
//   clog2()        : index width helper, never returns less than 1
package uart_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } arb_state_t;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      if (result < 1) result = 1;
      return result;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder.
//   req    : request vector, one bit per requester
//   rr_ptr : index of the requester served last; scanning starts just after it
//   winner : index of the first set request bit in round-robin order
//   valid  : high when any request bit is set
module rr_picker
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   logic [IDX_W-1:0]     start;
   logic [2*NUM_REQ-1:0] doubled;
   logic [NUM_REQ-1:0]   rotated;
   logic [31:0]          sum;

   // Rotating a doubled copy of req puts the highest-priority requester at
   // bit 0, so a plain lowest-set-bit search gives the round-robin winner.
   always_comb begin
      start   = (rr_ptr == IDX_W'(NUM_REQ - 1)) ? '0 : rr_ptr + 1'b1;
      doubled = {req, req};
      rotated = doubled[start +: NUM_REQ];
      winner  = '0;
      valid   = 1'b0;
      sum     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!valid && rotated[k]) begin
            valid = 1'b1;
            sum   = 32'(start) + k;
            if (sum >= 32'(NUM_REQ)) sum = sum - 32'(NUM_REQ);
            winner = IDX_W'(sum);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ requesters.
//   clk         : system clock, rising edge
//   reset       : asynchronous, active-low
//   req         : per-requester request level
//   req_data    : byte of requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt         : one-hot accept pulse; data captured on this cycle
//   tx_start    : one-cycle start pulse to the serializer
//   tx_data     : latched byte, held until the next grant
//   tx_done     : end-of-frame pulse from the serializer
//   active_id   : index of the requester being served
//   busy        : high outside IDLE
//   timeout_err : pulse when the watchdog aborts a transaction
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          tx_start,
   output logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_done,
   output logic [clog2(NUM_REQ)-1:0]     active_id,
   output logic                          busy,
   output logic                          timeout_err
);

   localparam int              ID_W    = clog2(NUM_REQ);
   localparam int              WD_W    = clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

   arb_state_t            state;
   logic [ID_W-1:0]       rr_ptr;
   logic [ID_W-1:0]       winner;
   logic                  win_valid;
   logic [WD_W-1:0]       wd_cnt;
   logic [DATA_WIDTH-1:0] slot [NUM_REQ];

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         slot[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (ID_W)
   ) u_picker (
      .req    (req),
      .rr_ptr (rr_ptr),
      .winner (winner),
      .valid  (win_valid)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         gnt         <= '0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         active_id   <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         rr_ptr      <= ID_LAST;
         wd_cnt      <= '0;
      end else begin
         gnt         <= '0;
         tx_start    <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (win_valid) begin
                  tx_data   <= slot[winner];
                  active_id <= winner;
                  gnt       <= NUM_REQ'(1) << winner;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               tx_start <= 1'b1;
               wd_cnt   <= '0;
               state    <= WAIT_DONE;
            end
            WAIT_DONE: begin
               // Counter holds at its terminal value rather than wrapping.
               if (wd_cnt != WD_LAST) wd_cnt <= wd_cnt + 1'b1;
               // tx_done takes precedence over a simultaneous timeout.
               if (tx_done) begin
                  rr_ptr <= active_id;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end else if (wd_cnt == WD_LAST) begin
                  timeout_err <= 1'b1;
                  rr_ptr      <= active_id;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
// A transaction-level model predicts the round-robin winner and the cycle
// timing of gnt, tx_start, tx_done completion and watchdog abort.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DW      = 8;
   localparam int TMO     = 16;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic [NUM_REQ-1:0]     req;
   logic [NUM_REQ*DW-1:0]  req_data;
   logic [NUM_REQ-1:0]     gnt;
   logic                   tx_start;
   logic [DW-1:0]          tx_data;
   logic                   tx_done;
   logic [1:0]             active_id;
   logic                   busy;
   logic                   timeout_err;

   int checks   = 0;
   int failures = 0;
   int last_id;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_data    (req_data),
      .gnt         (gnt),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .active_id   (active_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Round-robin rule: first requester after the last one served, wrapping.
   function automatic int model_pick(input logic [3:0] mask, input int last);
      int idx;
      for (int j = 1; j <= NUM_REQ; j++) begin
         idx = (last + j) % NUM_REQ;
         if (mask[idx]) return idx;
      end
      return -1;
   endfunction

   // One transaction starting in an IDLE cycle (called #1 after an edge).
   // d < TMO : tx_done is driven in the cycle d after the tx_start cycle.
   // d >= TMO: no tx_done, watchdog expected to abort.
   task automatic do_txn(input logic [3:0] mask, input logic [31:0] data,
                         input int d, input bit issue_done);
      int w;
      logic [7:0] exp_byte;
      w        = model_pick(mask, last_id);
      exp_byte = data[w*8 +: 8];
      req      = mask;
      req_data = data;
      @(posedge clk); #1;
      check("gnt", 32'(gnt), 32'(1 << w));
      check("active_id", 32'(active_id), 32'(w));
      check("busy_issue", 32'(busy), 1);
      check("start_early", 32'(tx_start), 0);
      req     = 4'($urandom);
      tx_done = issue_done;
      @(posedge clk); #1;
      tx_done = 1'b0;
      check("tx_start", 32'(tx_start), 1);
      check("tx_data", 32'(tx_data), 32'(exp_byte));
      check("gnt_clear", 32'(gnt), 0);
      if (d < TMO) begin
         for (int k = 0; k <= d; k++) begin
            if (k == d) tx_done = 1'b1;
            check("no_tmo", 32'(timeout_err), 0);
            if (k > 0) check("wait_gnt", 32'(gnt), 0);
            req = 4'($urandom);
            @(posedge clk); #1;
            tx_done = 1'b0;
         end
         check("done_idle", 32'(busy), 0);
         check("done_no_tmo", 32'(timeout_err), 0);
         check("held_data", 32'(tx_data), 32'(exp_byte));
      end else begin
         for (int k = 0; k < TMO; k++) begin
            check("wait_busy", 32'(busy), 1);
            check("no_tmo_early", 32'(timeout_err), 0);
            req = 4'($urandom);
            @(posedge clk); #1;
         end
         check("tmo_pulse", 32'(timeout_err), 1);
         check("tmo_idle", 32'(busy), 0);
      end
      check("idle_gnt", 32'(gnt), 0);
      last_id = w;
      req     = '0;
   endtask

   // Stray tx_done while idle must change nothing.
   task automatic idle_stray();
      tx_done = 1'b1;
      @(posedge clk); #1;
      tx_done = 1'b0;
      check("stray_busy", 32'(busy), 0);
      check("stray_gnt", 32'(gnt), 0);
      check("stray_start", 32'(tx_start), 0);
      check("stray_tmo", 32'(timeout_err), 0);
   endtask

   initial begin
      logic [3:0]  m;
      logic [31:0] dat;
      req      = '0;
      req_data = '0;
      tx_done  = 1'b0;
      last_id  = NUM_REQ - 1;

      #2 reset = 1'b0;
      #2;
      check("rst_gnt", 32'(gnt), 0);
      check("rst_start", 32'(tx_start), 0);
      check("rst_data", 32'(tx_data), 0);
      check("rst_id", 32'(active_id), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_tmo", 32'(timeout_err), 0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("idle_busy", 32'(busy), 0);

      // All requesting: order 0,1,2,3,0 with bytes 10,11,12,13,10.
      for (int n = 0; n < 5; n++) do_txn(4'b1111, 32'h1312_1110, 10, 1'b0);
      // Single request.
      do_txn(4'b0100, 32'h00A5_0000, 3, 1'b0);
      // Fairness across the wrap point.
      do_txn(4'b1000, 32'h7700_0000, 2, 1'b0);
      do_txn(4'b1001, 32'h5500_0066, 2, 1'b0);
      do_txn(4'b1001, 32'h5500_0066, 2, 1'b0);
      // Watchdog abort, then the next requester is served.
      do_txn(4'b0010, 32'h0000_3C00, 99, 1'b0);
      idle_stray();
      do_txn(4'b1111, 32'hDDCC_BBAA, 0, 1'b1);
      // tx_done on the terminal watchdog cycle wins.
      do_txn(4'b0001, 32'h0000_00E7, TMO - 1, 1'b0);
      idle_stray();

      // Reset during the tx_start cycle clears outputs without a clock edge.
      req      = 4'b1111;
      req_data = 32'h4433_2211;
      @(posedge clk); #1;
      req = '0;
      @(posedge clk); #1;
      check("pre_rst_start", 32'(tx_start), 1);
      #2 reset = 1'b0;
      #1;
      check("arst_start", 32'(tx_start), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_data", 32'(tx_data), 0);
      check("arst_id", 32'(active_id), 0);
      @(posedge clk); @(posedge clk); #1;
      reset   = 1'b1;
      last_id = NUM_REQ - 1;
      check("post_rst_gnt", 32'(gnt), 0);
      do_txn(4'b1111, 32'h4433_2211, 5, 1'b0);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         m = 4'($urandom_range(1, 15));
         dat = $urandom;
         do_txn(m, dat, int'($urandom_range(0, 20)), 1'($urandom));
         if ($urandom_range(0, 3) == 0) idle_stray();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
